// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, access sizes,
// FSM state type and the byte-strobe / offset-alignment helpers.
// Latency: n/a (declarations only). Backpressure: n/a.
package lsu_pkg;

    // Load encodings; stores reuse bits [1:0] as the size field.
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;
    localparam logic [2:0] F3_ILL = 3'b111;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    // Unshifted byte-enable pattern for an access of the given size.
    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    size_mask = 8'h01;
            SZ_H:    size_mask = 8'h03;
            SZ_W:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    endfunction

    // Clears the low log2(size) offset bits so the access lands on its natural boundary.
    function automatic logic [2:0] align_offset(input logic [2:0] off, input logic [1:0] size);
        case (size)
            SZ_B:    align_offset = off;
            SZ_H:    align_offset = {off[2:1], 1'b0};
            SZ_W:    align_offset = {off[2], 2'b00};
            default: align_offset = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: shifts store data/strobes into their doubleword lanes and
// extracts + sign/zero-extends load data. Purely combinational, no backpressure.
// Ports: st_* store path in (data/offset/size), ld_* load path in, wdata/wstrb/rdata_ext out.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [63:0] st_data,
    input  logic [2:0]  st_offset,
    input  logic [1:0]  st_size,
    input  logic [63:0] ld_data,
    input  logic [2:0]  ld_offset,
    input  logic [1:0]  ld_size,
    input  logic        ld_sign,
    output logic [63:0] wdata,
    output logic [7:0]  wstrb,
    output logic [63:0] rdata_ext
);

    logic [63:0] ld_shifted;

    always_comb begin
        wdata      = st_data << {st_offset, 3'b000};
        wstrb      = size_mask(st_size) << st_offset;
        ld_shifted = ld_data >> {ld_offset, 3'b000};
        case (ld_size)
            SZ_B:    rdata_ext = {{56{ld_sign & ld_shifted[7]}},  ld_shifted[7:0]};
            SZ_H:    rdata_ext = {{48{ld_sign & ld_shifted[15]}}, ld_shifted[15:0]};
            SZ_W:    rdata_ext = {{32{ld_sign & ld_shifted[31]}}, ld_shifted[31:0]};
            default: rdata_ext = ld_shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory initiator: one load/store per transaction, doubleword-granular strobed request.
// Latency: 2 cycles accept-to-done with zero-wait memory (+1 per wait cycle); errors finish in 1.
// Backpressure: lsu_ready only in IDLE; mem_req held until mem_ack or timeout abort.
// Ports: core side (MemRead/MemWrite/lsu_valid/lsu_ready/funct3/address/WriteData/ReadData/
// lsu_done/lsu_err), memory side (mem_req/we/addr/wdata/wstrb/ack/rdata).
// Build option: define LSU_MISALIGN_TRAP_EN to trap misaligned accesses instead of force-aligning.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int ADDR_W         = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] address,
    input  logic [63:0]       WriteData,
    output logic [63:0]       ReadData,
    output logic              lsu_done,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-4:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_ack,
    input  logic [63:0]       mem_rdata
);

    localparam int              CNT_W      = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit              TIMEOUT_EN = (TIMEOUT_CYCLES > 0);

    lsu_state_t       state, state_nxt;
    logic [CNT_W-1:0] to_cnt;
    logic [2:0]       off_q;
    logic [1:0]       size_q;
    logic             sign_q;
    logic             err_q;

    logic [1:0]  req_size;
    logic [2:0]  eff_off;
    logic        illegal;
    logic        misalign;
    logic        acc_err;
    logic        accept;
    logic        timed_out;
    logic [63:0] st_wdata;
    logic [7:0]  st_wstrb;
    logic [63:0] ld_ext;

    assign req_size = funct3[1:0];

    always_comb begin
        illegal = (MemRead == MemWrite) || (MemRead && (funct3 == F3_ILL));
        eff_off = align_offset(address[2:0], req_size);
`ifdef LSU_MISALIGN_TRAP_EN
        misalign = (eff_off != address[2:0]);
`else
        misalign = 1'b0;
`endif
        acc_err = illegal | misalign;
    end

    assign accept = (state == ST_IDLE) && lsu_valid;
    // Abort on the last counted cycle only when no ack arrives: a coinciding ack wins.
    assign timed_out = TIMEOUT_EN && (to_cnt == CNT_LAST) && !mem_ack;

    lsu_align u_align (
        .st_data   (WriteData),
        .st_offset (eff_off),
        .st_size   (req_size),
        .ld_data   (mem_rdata),
        .ld_offset (off_q),
        .ld_size   (size_q),
        .ld_sign   (sign_q),
        .wdata     (st_wdata),
        .wstrb     (st_wstrb),
        .rdata_ext (ld_ext)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (lsu_valid) state_nxt = acc_err ? ST_RESP : ST_ACCESS;
            ST_ACCESS: if (mem_ack || timed_out) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Decoded straight from the state register so reset drops mem_req asynchronously.
    assign lsu_ready = (state == ST_IDLE);
    assign mem_req   = (state == ST_ACCESS);
    assign lsu_done  = (state == ST_RESP);
    assign lsu_err   = lsu_done & err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            to_cnt    <= '0;
            off_q     <= 3'b000;
            size_q    <= SZ_B;
            sign_q    <= 1'b0;
            err_q     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            ReadData  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                mem_addr  <= address[ADDR_W-1:3];
                mem_we    <= MemWrite;
                mem_wdata <= st_wdata;
                mem_wstrb <= MemWrite ? st_wstrb : 8'hFF;
                off_q     <= eff_off;
                size_q    <= req_size;
                sign_q    <= ~funct3[2];
                err_q     <= acc_err;
                to_cnt    <= '0;
            end
            if (state == ST_ACCESS) begin
                if (mem_ack) begin
                    if (!mem_we) ReadData <= ld_ext;
                end else begin
                    if (timed_out) err_q <= 1'b1;
                    to_cnt <= to_cnt + 1'b1;
                end
            end
        end
    end

endmodule
